// File: rtl/uart_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module   : uart_pkg                                                  |
// | Purpose  : Shared UART definitions: FSM state encoding, frame data   |
// |            width and the bit-period calculation used by uart_tx and  |
// |            uart_rx.                                                  |
// | Ports    : none (package)                                            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Clock cycles per serial bit (truncating division).
  function automatic int calc_baud_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module   : uart_tx_fifo                                              |
// | Purpose  : Single-clock synchronous FIFO, no output register: the    |
// |            head entry is visible on rd_data whenever empty=0.        |
// | Ports    : clk, rst (sync, active high)                              |
// |            wr_en/wr_data  - push request and data                    |
// |            rd_en          - pop request (ignored when empty)         |
// |            rd_data        - current head entry                       |
// |            full, empty    - decoded from the registered count        |
// |            count          - number of stored entries                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = DATA_BITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign full    = (r_count == C_DEPTH);
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];

  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // still accepted then. When full the write slot equals the read slot;
  // the head is consumed from the pre-edge contents, so this is safe.
  assign w_rd = rd_en && !empty;
  assign w_wr = wr_en && (!full || w_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers are AW bits wide, so they wrap modulo DEPTH.
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; entries are only read while count > 0.
  always_ff @(posedge clk) begin
    if (w_wr && !rst) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module   : uart_tx                                                   |
// | Purpose  : Buffered 8N1 UART transmitter. Bytes pushed on pi_flag    |
// |            are queued in a FIFO and sent LSB first, back to back.    |
// | Ports    : sys_clk     - clock, rising edge                          |
// |            sys_rst     - synchronous active-high reset               |
// |            pi_data     - byte to transmit                            |
// |            pi_flag     - one-cycle push strobe                       |
// |            tx          - registered serial line, idle high           |
// |            po_full     - FIFO holds FIFO_DEPTH entries               |
// |            po_busy     - frame in progress or FIFO non-empty         |
// |            po_overflow - sticky: a push was dropped                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module uart_tx
  import uart_pkg::*;
#(
  parameter logic [19:0] UART_BPS   = 20'd115200,
  parameter logic [25:0] CLK_FREQ   = 26'd50_000_000,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [DATA_BITS-1:0] pi_data,
  input  logic                 pi_flag,
  output logic                 tx,
  output logic                 po_full,
  output logic                 po_busy,
  output logic                 po_overflow
);

  localparam int BAUD_CNT = calc_baud_cnt(int'(CLK_FREQ), int'(UART_BPS));
  localparam int CW       = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
  localparam int BW       = $clog2(DATA_BITS);
  localparam int AW       = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] C_BAUD_LAST = CW'(BAUD_CNT - 1);
  localparam logic [BW-1:0] C_BIT_LAST  = BW'(DATA_BITS - 1);

  uart_state_t          r_state;
  logic                 r_tx;
  logic [CW-1:0]        r_baud_cnt;
  logic [BW-1:0]        r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_overflow;

  logic                 w_bit_end;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [DATA_BITS-1:0] w_rd_data;
  logic [AW:0]          w_count;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .wr_en   (pi_flag),
    .wr_data (pi_data),
    .rd_en   (w_pop),
    .rd_data (w_rd_data),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  assign w_bit_end = (r_baud_cnt == C_BAUD_LAST);

  // Pop conditions must mirror the FSM transitions that load r_shift.
  assign w_pop = !w_empty &&
                 ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

  assign tx          = r_tx;
  assign po_full     = w_full;
  assign po_busy     = (r_state != IDLE) || (w_count != '0);
  assign po_overflow = r_overflow;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= IDLE;
      r_tx       <= 1'b1;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
    end else begin
      // Bit timer free-runs 0..BAUD_CNT-1 while a frame is active.
      if (r_state == IDLE) r_baud_cnt <= '0;
      else if (w_bit_end)  r_baud_cnt <= '0;
      else                 r_baud_cnt <= r_baud_cnt + CW'(1);

      case (r_state)
        IDLE: begin
          r_tx      <= 1'b1;
          r_bit_idx <= '0;
          if (!w_empty) begin
            r_shift <= w_rd_data;
            r_tx    <= 1'b0;
            r_state <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= DATA;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == C_BIT_LAST) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bit_idx <= r_bit_idx + BW'(1);
              r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
              // Next bit is shift[1]: drive it now so tx stays registered.
              r_tx      <= r_shift[1];
            end
          end
        end
        STOP: begin
          if (w_bit_end) begin
            if (!w_empty) begin
              // Chain straight into the next start bit, no idle gap.
              r_shift <= w_rd_data;
              r_tx    <= 1'b0;
              r_state <= START;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Sticky until reset; a push on a full FIFO is only lost with no pop.
  always_ff @(posedge sys_clk) begin
    if (sys_rst)                          r_overflow <= 1'b0;
    else if (pi_flag && w_full && !w_pop) r_overflow <= 1'b1;
  end

endmodule
`default_nettype wire
